// File: rtl/sram_rd_pkg.sv
// Shared types and constants for the SRAM packet read-out controller.
package sram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;

  localparam int RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/sram_rd_skid_fifo.sv
// Two-entry skid buffer that catches SRAM read data returning one cycle after issue.
module sram_rd_skid_fifo
  import sram_rd_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [RD_FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;

  // The controller's credit rule guarantees no push when full and no pop when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/sram_rd_ctrl.sv
// Reads a (start address, length) burst from the SRAM B port and streams it out
// as valid/ready words with a last flag, absorbing the one-cycle read latency.
module sram_rd_ctrl
  import sram_rd_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 15,
  parameter int LWIDTH = 12
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [AWIDTH-1:0] req_addr_in,
  input  logic [LWIDTH-1:0] req_len_in,
  output logic              sram_en_out,
  output logic              sram_we_out,
  output logic [AWIDTH-1:0] sram_addr_out,
  input  logic [DWIDTH-1:0] sram_d_in,
  output logic              dout_valid_out,
  input  logic              dout_ready_in,
  output logic [DWIDTH-1:0] dout_data_out,
  output logic              dout_last_out,
  output logic              done_out,
  output logic              busy_out
);

  rd_state_e         state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [LWIDTH-1:0] remaining_q, remaining_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              zero_done_q, zero_done_d;

  logic              req_hs;
  logic              issue;
  logic              pop;
  logic              last_pop;
  logic              credit_ok;
  logic [1:0]        occ;
  logic [DWIDTH:0]   fifo_head;

  assign req_ready_out = (state_q == IDLE);
  assign req_hs        = req_valid_in && req_ready_out;
  assign dout_valid_out = (occ != 2'd0);
  assign pop           = dout_valid_out && dout_ready_in;
  assign last_pop      = pop && dout_last_out;

  // Buffered words plus the one in flight must fit in the skid FIFO; a pop frees a slot.
  assign credit_ok = ((occ + {1'b0, inflight_q}) < 2'(RD_FIFO_DEPTH)) || pop;
  assign issue     = (state_q == READ) && (remaining_q != '0) && credit_ok;

  assign sram_en_out   = issue;
  assign sram_we_out   = 1'b0;
  assign sram_addr_out = addr_q;
  assign dout_data_out = fifo_head[DWIDTH-1:0];
  assign dout_last_out = dout_valid_out && fifo_head[DWIDTH];
  assign busy_out      = (state_q != IDLE);
  assign done_out      = zero_done_q || ((state_q == DRAIN) && last_pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          if (req_len_in != '0) begin
            addr_d      = req_addr_in;
            remaining_d = req_len_in;
            state_d     = READ;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LWIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clearing inflight on reset discards any read data still returning from the SRAM.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LWIDTH'(1));
      zero_done_q     <= zero_done_d;
    end
  end

  sram_rd_skid_fifo #(
    .W(DWIDTH + 1)
  ) u_skid_fifo (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, sram_d_in}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .occ_o      (occ)
  );

endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Directed self-checking bench for sram_rd_ctrl, with a behavioural one-cycle-latency SRAM port.
module tb_sram_rd_ctrl;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 15;
  localparam int LWIDTH = 12;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              req_valid_in;
  logic              req_ready_out;
  logic [AWIDTH-1:0] req_addr_in;
  logic [LWIDTH-1:0] req_len_in;
  logic              sram_en_out;
  logic              sram_we_out;
  logic [AWIDTH-1:0] sram_addr_out;
  logic [DWIDTH-1:0] sram_d_in = '0;
  logic              dout_valid_out;
  logic              dout_ready_in;
  logic [DWIDTH-1:0] dout_data_out;
  logic              dout_last_out;
  logic              done_out;
  logic              busy_out;

  always #5 clk_in = ~clk_in;

  sram_rd_ctrl #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH),
    .LWIDTH(LWIDTH)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_addr_in   (req_addr_in),
    .req_len_in    (req_len_in),
    .sram_en_out   (sram_en_out),
    .sram_we_out   (sram_we_out),
    .sram_addr_out (sram_addr_out),
    .sram_d_in     (sram_d_in),
    .dout_valid_out(dout_valid_out),
    .dout_ready_in (dout_ready_in),
    .dout_data_out (dout_data_out),
    .dout_last_out (dout_last_out),
    .done_out      (done_out),
    .busy_out      (busy_out)
  );

  logic [DWIDTH-1:0] sramMem [0:(1<<AWIDTH)-1];

  always @(posedge clk_in) begin
    if (sram_en_out && !sram_we_out) sram_d_in <= sramMem[sram_addr_out];
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int passCount = 0;
  int checkCount = 0;

  logic [DWIDTH-1:0] popData [$];
  logic              popLast [$];
  int                popCyc [$];
  logic [AWIDTH-1:0] issAddr [$];
  int                issCyc [$];
  int                doneCyc [$];
  int                outstanding, maxOutstanding, stabErr, readyLowCnt;
  logic              prevStall;
  logic [DWIDTH-1:0] prevData;
  logic              prevLast;

  // Passive monitor: records issues, pops, done pulses and stream-stability violations.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && (!dout_valid_out || dout_data_out !== prevData || dout_last_out !== prevLast))
        stabErr++;
      if (sram_en_out) begin
        issAddr.push_back(sram_addr_out);
        issCyc.push_back(cyc);
        outstanding++;
      end
      if (dout_valid_out && dout_ready_in) begin
        popData.push_back(dout_data_out);
        popLast.push_back(dout_last_out);
        popCyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > maxOutstanding) maxOutstanding = outstanding;
      if (done_out) doneCyc.push_back(cyc);
      if (!req_ready_out) readyLowCnt++;
      prevStall = dout_valid_out && !dout_ready_in;
      prevData  = dout_data_out;
      prevLast  = dout_last_out;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic clearMon();
    popData.delete(); popLast.delete(); popCyc.delete();
    issAddr.delete(); issCyc.delete(); doneCyc.delete();
    outstanding = 0; maxOutstanding = 0; stabErr = 0; readyLowCnt = 0;
  endtask

  // Entered just after a rising edge; holds the request for one cycle.
  task automatic applyStimulus(input logic [AWIDTH-1:0] addr, input logic [LWIDTH-1:0] len, output int hsCyc);
    req_valid_in = 1'b1;
    req_addr_in  = addr;
    req_len_in   = len;
    @(negedge clk_in);
    hsCyc = cyc;
    checkOutput($sformatf("hs_ready_%0h", addr), req_ready_out, 1'b1);
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
  endtask

  task automatic runUntilDone(input int budget, input bit throttle);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (throttle) dout_ready_in = (i % 3 == 0);
      @(negedge clk_in);
      if (done_out) seen = 1'b1;
      if (!seen) begin
        @(posedge clk_in); #1;
      end
    end
    #1;
    dout_ready_in = 1'b1;
    checkOutput("done_seen", seen, 1'b1);
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_req_ready"}, req_ready_out, 1'b1);
    checkOutput({pfx, "_sram_en"}, sram_en_out, 1'b0);
    checkOutput({pfx, "_sram_we"}, sram_we_out, 1'b0);
    checkOutput({pfx, "_sram_addr"}, sram_addr_out, 32'h0);
    checkOutput({pfx, "_dout_valid"}, dout_valid_out, 1'b0);
    checkOutput({pfx, "_dout_last"}, dout_last_out, 1'b0);
    checkOutput({pfx, "_dout_data"}, dout_data_out, 32'h0);
    checkOutput({pfx, "_done"}, done_out, 1'b0);
    checkOutput({pfx, "_busy"}, busy_out, 1'b0);
  endtask

  task automatic checkWords(input string pfx, input int n, input logic [AWIDTH-1:0] base);
    checkOutput({pfx, "_word_count"}, popData.size(), n);
    for (int k = 0; k < n; k++) begin
      logic [AWIDTH-1:0] a;
      a = base + AWIDTH'(k);
      checkOutput($sformatf("%s_data%0d", pfx, k), (k < popData.size()) ? popData[k] : 'x, 32'hC000_0000 | 32'(a));
      checkOutput($sformatf("%s_last%0d", pfx, k), (k < popLast.size()) ? popLast[k] : 1'bx, (k == n - 1));
    end
  endtask

  initial begin
    int reqCyc;
    int firstDone;
    logic [AWIDTH-1:0] wrapAddr [4];
    wrapAddr = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

    for (int i = 0; i < (1 << AWIDTH); i++) sramMem[i] = 32'hC000_0000 | i;
    sramMem[15'h100] = 32'hA0;
    sramMem[15'h101] = 32'hA1;
    sramMem[15'h102] = 32'hA2;
    sramMem[15'h103] = 32'hA3;

    rst_n_in = 1'b0; req_valid_in = 1'b0; req_addr_in = '0; req_len_in = '0; dout_ready_in = 1'b1;
    clearMon();
    #2;
    checkResetValues("por");
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Basic 4-word read with the consumer always ready.
    clearMon();
    applyStimulus(15'h100, 12'd4, reqCyc);
    runUntilDone(40, 1'b0);
    checkOutput("basic_count", popData.size(), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("basic_data%0d", k), (k < popData.size()) ? popData[k] : 'x, 32'hA0 + k);
      checkOutput($sformatf("basic_cyc%0d", k), (k < popCyc.size()) ? popCyc[k] : -1, reqCyc + 3 + k);
      checkOutput($sformatf("basic_last%0d", k), (k < popLast.size()) ? popLast[k] : 1'bx, (k == 3));
      checkOutput($sformatf("basic_addr%0d", k), (k < issAddr.size()) ? issAddr[k] : 'x, 32'h100 + k);
    end
    checkOutput("basic_first_issue_cyc", (issCyc.size() > 0) ? issCyc[0] : -1, reqCyc + 1);
    checkOutput("basic_done_cyc", (doneCyc.size() > 0) ? doneCyc[0] : -1, reqCyc + 6);
    @(posedge clk_in); #1;

    // Address wrap across the top of the SRAM.
    clearMon();
    applyStimulus(15'h7FFE, 12'd4, reqCyc);
    runUntilDone(40, 1'b0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("wrap_addr%0d", k), (k < issAddr.size()) ? issAddr[k] : 'x, wrapAddr[k]);
    checkWords("wrap", 4, 15'h7FFE);
    @(posedge clk_in); #1;

    // Backpressure with ready pattern 1,0,0 repeating.
    clearMon();
    applyStimulus(15'h200, 12'd8, reqCyc);
    runUntilDone(120, 1'b1);
    checkWords("bp", 8, 15'h200);
    checkOutput("bp_issue_count", issAddr.size(), 8);
    checkOutput("bp_max_buffered_le2", (maxOutstanding <= 2), 1'b1);
    checkOutput("bp_stable_errors", stabErr, 0);
    checkOutput("bp_done_count", doneCyc.size(), 1);
    @(posedge clk_in); #1;

    // Zero-length request.
    clearMon();
    applyStimulus(15'h300, 12'd0, reqCyc);
    runUntilDone(10, 1'b0);
    repeat (4) @(posedge clk_in);
    #1;
    checkOutput("zero_issue_count", issAddr.size(), 0);
    checkOutput("zero_pop_count", popData.size(), 0);
    checkOutput("zero_done_count", doneCyc.size(), 1);
    checkOutput("zero_done_cyc", (doneCyc.size() > 0) ? doneCyc[0] : -1, reqCyc + 1);
    checkOutput("zero_ready_low", readyLowCnt, 0);
    @(posedge clk_in); #1;

    // Reset after 3 of 10 words, then a fresh 2-word request.
    clearMon();
    applyStimulus(15'h400, 12'd10, reqCyc);
    for (int i = 0; i < 40 && popData.size() < 3; i++) begin
      @(posedge clk_in); #1;
    end
    checkOutput("rst_words_before", popData.size(), 3);
    rst_n_in = 1'b0;
    #1;
    checkResetValues("midrst");
    checkOutput("rst_no_done", doneCyc.size(), 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    clearMon();
    applyStimulus(15'h500, 12'd2, reqCyc);
    runUntilDone(40, 1'b0);
    repeat (4) @(posedge clk_in);
    #1;
    checkWords("postrst", 2, 15'h500);
    checkOutput("postrst_done_count", doneCyc.size(), 1);
    @(posedge clk_in); #1;

    // Back-to-back: second request in the cycle right after done.
    clearMon();
    applyStimulus(15'h600, 12'd2, reqCyc);
    runUntilDone(40, 1'b0);
    checkWords("b2b_first", 2, 15'h600);
    firstDone = (doneCyc.size() > 0) ? doneCyc[0] : -100;
    @(posedge clk_in); #1;
    clearMon();
    applyStimulus(15'h610, 12'd3, reqCyc);
    checkOutput("b2b_hs_cyc", reqCyc, firstDone + 1);
    runUntilDone(40, 1'b0);
    checkOutput("b2b_issue_cyc", (issCyc.size() > 0) ? issCyc[0] : -1, reqCyc + 1);
    checkOutput("b2b_issue_addr", (issAddr.size() > 0) ? issAddr[0] : 'x, 32'h610);
    checkWords("b2b_second", 3, 15'h610);

    repeat (2) @(posedge clk_in);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
